// File: rtl/mem_lsu_stage_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
// The default datapath width is 32; instantiations override it through the XLEN parameter.
package mem_lsu_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Memory-op field layout: [4]access [3]store [2]unsigned [1:0]size
    localparam int MEM_OP_W        = 5;
    localparam int MEM_OP_ACCESS   = 4;
    localparam int MEM_OP_STORE    = 3;
    localparam int MEM_OP_UNSIGNED = 2;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_D = 2'd3;

    // Operation details kept while a bus transaction is outstanding
    typedef struct packed {
        logic       store;
        logic       uns;
        logic [1:0] size;
    } mem_op_t;

    // A doubleword access on a 32-bit datapath degrades to a word access
    function automatic logic [1:0] eff_size(input logic [1:0] size, input logic wide);
        if ((size == MEM_SIZE_D) && !wide) begin
            return MEM_SIZE_W;
        end
        return size;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Store side: byte enables and lane-replicated write data.
// Load side: shift the addressed bytes down to bit 0 and sign/zero extend.
module mem_lsu_align
    import mem_lsu_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    localparam int BEW = XLEN / 8,
    localparam int OFFW = $clog2(BEW)
) (
    input  logic [1:0]      st_size_i,
    input  logic [OFFW-1:0] st_offset_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [BEW-1:0]  st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    input  logic [1:0]      ld_size_i,
    input  logic            ld_unsigned_i,
    input  logic [OFFW-1:0] ld_offset_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [BEW-1:0]  beBase;
    logic [XLEN-1:0] ldShifted;

    // Build the byte-enable mask for the access size and replicate the low bytes on every lane
    always_comb begin
        beBase     = '0;
        st_wdata_o = st_data_i;
        case (st_size_i)
            MEM_SIZE_B: begin
                beBase     = BEW'(1);
                st_wdata_o = {BEW{st_data_i[7:0]}};
            end
            MEM_SIZE_H: begin
                beBase     = BEW'(3);
                st_wdata_o = {(BEW/2){st_data_i[15:0]}};
            end
            MEM_SIZE_W: begin
                beBase     = BEW'(15);
                st_wdata_o = {(BEW/4){st_data_i[31:0]}};
            end
            default: begin
                beBase     = '1;
                st_wdata_o = st_data_i;
            end
        endcase
        st_be_o = beBase << st_offset_i;
    end

    // Bring the addressed lane to bit 0 and extend according to size and signedness
    always_comb begin
        ldShifted = ld_rdata_i >> {ld_offset_i, 3'b000};
        case (ld_size_i)
            MEM_SIZE_B: ld_data_o = ld_unsigned_i ? XLEN'(ldShifted[7:0])
                                                  : XLEN'($signed(ldShifted[7:0]));
            MEM_SIZE_H: ld_data_o = ld_unsigned_i ? XLEN'(ldShifted[15:0])
                                                  : XLEN'($signed(ldShifted[15:0]));
            MEM_SIZE_W: ld_data_o = ld_unsigned_i ? XLEN'(ldShifted[31:0])
                                                  : XLEN'($signed(ldShifted[31:0]));
            default:    ld_data_o = ldShifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM stage with a load/store unit. Register-only ops reach WB one cycle later;
// loads and stores run a req/gnt/rvalid transaction and stall EXE while in flight.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses are reported
// instead of issued; when undefined the offset is rounded down to the access size).
module mem_lsu_stage
    import mem_lsu_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RADDR_W = 5,
    localparam int BEW = XLEN / 8,
    localparam int OFFW = $clog2(BEW)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [RADDR_W-1:0]  ex_rd_addr_i,
    input  logic [XLEN-1:0]     ex_rd_data_i,
    input  logic                ex_rd_we_i,
    input  logic [MEM_OP_W-1:0] ex_mem_op_i,
    input  logic [XLEN-1:0]     ex_store_data_i,
    output logic                dbus_req_o,
    output logic                dbus_we_o,
    output logic [XLEN-1:0]     dbus_addr_o,
    output logic [BEW-1:0]      dbus_be_o,
    output logic [XLEN-1:0]     dbus_wdata_o,
    input  logic                dbus_gnt_i,
    input  logic                dbus_rvalid_i,
    input  logic [XLEN-1:0]     dbus_rdata_i,
    output logic                wb_valid_o,
    output logic [RADDR_W-1:0]  wb_rd_addr_o,
    output logic [XLEN-1:0]     wb_rd_data_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                misalign_o,
    output logic [XLEN-1:0]     misalign_addr_o,
`endif
    output logic                wb_rd_we_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     dbus_addr_q, dbus_addr_d;
    logic [BEW-1:0]      dbus_be_q, dbus_be_d;
    logic [XLEN-1:0]     dbus_wdata_q, dbus_wdata_d;
    mem_op_t             op_q, op_d;
    logic [OFFW-1:0]     ld_offset_q, ld_offset_d;
    logic [RADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic                rd_we_q, rd_we_d;
    logic                wb_valid_q, wb_valid_d;
    logic [RADDR_W-1:0]  wb_rd_addr_q, wb_rd_addr_d;
    logic [XLEN-1:0]     wb_rd_data_q, wb_rd_data_d;
    logic                wb_rd_we_q, wb_rd_we_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                misalign_q, misalign_d;
    logic [XLEN-1:0]     misalign_addr_q, misalign_addr_d;
    logic                exMisaligned;
`endif

    logic [1:0]          exSize;
    logic [OFFW-1:0]     exOffset;
    logic [OFFW-1:0]     exSizeMask;
    logic [OFFW-1:0]     exAlignedOffset;
    logic [BEW-1:0]      stBe;
    logic [XLEN-1:0]     stWdata;
    logic [XLEN-1:0]     ldData;

    // Decode the incoming access: effective size, lane offset and alignment
    always_comb begin
        exSize   = eff_size(ex_mem_op_i[1:0], XLEN == 64);
        exOffset = ex_rd_data_i[OFFW-1:0];
        case (exSize)
            MEM_SIZE_B: exSizeMask = '0;
            MEM_SIZE_H: exSizeMask = OFFW'(1);
            MEM_SIZE_W: exSizeMask = OFFW'(3);
            default:    exSizeMask = OFFW'(7);
        endcase
        exAlignedOffset = exOffset & ~exSizeMask;
`ifdef MEM_MISALIGN_TRAP_EN
        exMisaligned = |(exOffset & exSizeMask);
`endif
    end

    mem_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .st_size_i     (exSize),
        .st_offset_i   (exAlignedOffset),
        .st_data_i     (ex_store_data_i),
        .st_be_o       (stBe),
        .st_wdata_o    (stWdata),
        .ld_size_i     (op_q.size),
        .ld_unsigned_i (op_q.uns),
        .ld_offset_i   (ld_offset_q),
        .ld_rdata_i    (dbus_rdata_i),
        .ld_data_o     (ldData)
    );

    // Next-state logic: pass-through, access launch, grant and completion handling
    always_comb begin
        state_d      = state_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_be_d    = dbus_be_q;
        dbus_wdata_d = dbus_wdata_q;
        op_d         = op_q;
        ld_offset_d  = ld_offset_q;
        rd_addr_d    = rd_addr_q;
        rd_we_d      = rd_we_q;
        wb_valid_d   = 1'b0;
        wb_rd_we_d   = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_rd_data_d = wb_rd_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ex_valid_i) begin
                    if (!ex_mem_op_i[MEM_OP_ACCESS]) begin
                        wb_valid_d   = 1'b1;
                        wb_rd_addr_d = ex_rd_addr_i;
                        wb_rd_data_d = ex_rd_data_i;
                        wb_rd_we_d   = ex_rd_we_i && (ex_rd_addr_i != '0);
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (exMisaligned) begin
                        wb_valid_d      = 1'b1;
                        wb_rd_addr_d    = ex_rd_addr_i;
                        wb_rd_data_d    = '0;
                        misalign_d      = 1'b1;
                        misalign_addr_d = ex_rd_data_i;
                    end
`endif
                    else begin
                        state_d      = S_REQ;
                        dbus_addr_d  = {ex_rd_data_i[XLEN-1:OFFW], {OFFW{1'b0}}};
                        dbus_be_d    = stBe;
                        dbus_wdata_d = stWdata;
                        op_d.store   = ex_mem_op_i[MEM_OP_STORE];
                        op_d.uns     = ex_mem_op_i[MEM_OP_UNSIGNED];
                        op_d.size    = exSize;
                        ld_offset_d  = exAlignedOffset;
                        rd_addr_d    = ex_rd_addr_i;
                        rd_we_d      = ex_rd_we_i && !ex_mem_op_i[MEM_OP_STORE]
                                       && (ex_rd_addr_i != '0);
                    end
                end
            end
            S_REQ: begin
                if (dbus_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dbus_rvalid_i) begin
                    state_d      = S_IDLE;
                    wb_valid_d   = 1'b1;
                    wb_rd_addr_d = rd_addr_q;
                    wb_rd_we_d   = rd_we_q;
                    wb_rd_data_d = op_q.store ? '0 : ldData;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers; reset aborts any transaction in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            dbus_addr_q  <= '0;
            dbus_be_q    <= '0;
            dbus_wdata_q <= '0;
            op_q         <= '0;
            ld_offset_q  <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_data_q <= '0;
            wb_rd_we_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_be_q    <= dbus_be_d;
            dbus_wdata_q <= dbus_wdata_d;
            op_q         <= op_d;
            ld_offset_q  <= ld_offset_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_rd_data_q <= wb_rd_data_d;
            wb_rd_we_q   <= wb_rd_we_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
`endif
        end
    end

    assign ex_ready_o   = (state_q == S_IDLE);
    assign dbus_req_o   = (state_q == S_REQ);
    assign dbus_we_o    = op_q.store;
    assign dbus_addr_o  = dbus_addr_q;
    assign dbus_be_o    = dbus_be_q;
    assign dbus_wdata_o = dbus_wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_addr_o = wb_rd_addr_q;
    assign wb_rd_data_o = wb_rd_data_q;
    assign wb_rd_we_o   = wb_rd_we_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
`endif

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Testbench for mem_lsu_stage (32-bit datapath): table of single operations,
// a write-back scoreboard, and sequences for stalls, reset abort and bus noise.
module tb_mem_lsu_stage;

    localparam int XLEN = 32;
    localparam int RADDR_W = 5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic        ex_rd_we_i;
    logic [4:0]  ex_mem_op_i;
    logic [31:0] ex_store_data_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;
    logic        wb_rd_we_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
`endif

    typedef struct {
        string       name;
        logic        access;
        logic        store;
        logic        uns;
        logic [1:0]  size;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expWbData;
        logic        expWbWe;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        checkData;
    } wbExp_t;

    vec_t   vecs[$];
    wbExp_t expQ[$];
    int     compared = 0;
    int     mismatched = 0;

    mem_lsu_stage #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_rd_data_i    (ex_rd_data_i),
        .ex_rd_we_i      (ex_rd_we_i),
        .ex_mem_op_i     (ex_mem_op_i),
        .ex_store_data_i (ex_store_data_i),
        .dbus_req_o      (dbus_req_o),
        .dbus_we_o       (dbus_we_o),
        .dbus_addr_o     (dbus_addr_o),
        .dbus_be_o       (dbus_be_o),
        .dbus_wdata_o    (dbus_wdata_o),
        .dbus_gnt_i      (dbus_gnt_i),
        .dbus_rvalid_i   (dbus_rvalid_i),
        .dbus_rdata_i    (dbus_rdata_i),
        .wb_valid_o      (wb_valid_o),
        .wb_rd_addr_o    (wb_rd_addr_o),
        .wb_rd_data_o    (wb_rd_data_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o),
`endif
        .wb_rd_we_o      (wb_rd_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mkAlu(input string n, input logic [4:0] rd, input logic we,
                                   input logic [31:0] d, input logic expWe);
        vec_t v;
        v = '{name: n, access: 1'b0, store: 1'b0, uns: 1'b0, size: 2'd0, rd: rd, we: we,
              data: d, sdata: 32'h0, rdata: 32'h0, expAddr: 32'h0, expBe: 4'h0,
              expWdata: 32'h0, expWbData: d, expWbWe: expWe};
        return v;
    endfunction

    function automatic vec_t mkMem(input string n, input logic st, input logic u, input logic [1:0] sz,
                                   input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sd,
                                   input logic [31:0] rdat, input logic [31:0] eAddr, input logic [3:0] eBe,
                                   input logic [31:0] eWd, input logic [31:0] eWb, input logic eWe);
        vec_t v;
        v = '{name: n, access: 1'b1, store: st, uns: u, size: sz, rd: rd, we: 1'b1,
              data: addr, sdata: sd, rdata: rdat, expAddr: eAddr, expBe: eBe,
              expWdata: eWd, expWbData: eWb, expWbWe: eWe};
        return v;
    endfunction

    // Scoreboard: every write-back beat must match the oldest expectation
    always @(negedge clk_i) begin
        wbExp_t e;
        if (!rst_i && wb_valid_o) begin
            if (expQ.size() == 0) begin
                checkOutput("wbUnexpected", 64'(wb_valid_o), 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("wbRdAddr", 64'(wb_rd_addr_o), 64'(e.rd));
                checkOutput("wbRdWe", 64'(wb_rd_we_o), 64'(e.we));
                if (e.checkData) begin
                    checkOutput("wbRdData", 64'(wb_rd_data_o), 64'(e.data));
                end
            end
        end
    end

    task automatic pushExp(input logic [4:0] rd, input logic [31:0] d, input logic we, input logic chk);
        wbExp_t e;
        e = '{rd: rd, data: d, we: we, checkData: chk};
        expQ.push_back(e);
    endtask

    task automatic driveEx(input vec_t v);
        ex_valid_i      = 1'b1;
        ex_rd_addr_i    = v.rd;
        ex_rd_data_i    = v.data;
        ex_rd_we_i      = v.we;
        ex_mem_op_i     = {v.access, v.store, v.uns, v.size};
        ex_store_data_i = v.sdata;
    endtask

    // One operation with an immediately responding bus
    task automatic applyStimulus(input vec_t v);
        int k;
        driveEx(v);
        checkOutput({v.name, ":exReady"}, 64'(ex_ready_o), 64'd1);
        if (!v.access) begin
            pushExp(v.rd, v.expWbData, v.expWbWe, 1'b1);
            stepCycle();
            ex_valid_i = 1'b0;
            checkOutput({v.name, ":wbValid"}, 64'(wb_valid_o), 64'd1);
        end else begin
            stepCycle();
            ex_valid_i = 1'b0;
            k = 0;
            while (!dbus_req_o && k < 8) begin
                stepCycle();
                k++;
            end
            checkOutput({v.name, ":req"}, 64'(dbus_req_o), 64'd1);
            checkOutput({v.name, ":reqLatency"}, 64'(k), 64'd0);
            checkOutput({v.name, ":we"}, 64'(dbus_we_o), 64'(v.store));
            checkOutput({v.name, ":addr"}, 64'(dbus_addr_o), 64'(v.expAddr));
            checkOutput({v.name, ":be"}, 64'(dbus_be_o), 64'(v.expBe));
            if (v.store) begin
                checkOutput({v.name, ":wdata"}, 64'(dbus_wdata_o), 64'(v.expWdata));
            end
            checkOutput({v.name, ":exStall"}, 64'(ex_ready_o), 64'd0);
            dbus_gnt_i = 1'b1;
            stepCycle();
            dbus_gnt_i    = 1'b0;
            dbus_rvalid_i = 1'b1;
            dbus_rdata_i  = v.rdata;
            checkOutput({v.name, ":noWbInWait"}, 64'(wb_valid_o), 64'd0);
            pushExp(v.rd, v.expWbData, v.expWbWe, !v.store);
            stepCycle();
            dbus_rvalid_i = 1'b0;
            checkOutput({v.name, ":wbValid"}, 64'(wb_valid_o), 64'd1);
            checkOutput({v.name, ":readyAgain"}, 64'(ex_ready_o), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t   v;
        rst_i           = 1'b1;
        ex_valid_i      = 1'b0;
        ex_rd_addr_i    = '0;
        ex_rd_data_i    = '0;
        ex_rd_we_i      = 1'b0;
        ex_mem_op_i     = '0;
        ex_store_data_i = '0;
        dbus_gnt_i      = 1'b0;
        dbus_rvalid_i   = 1'b0;
        dbus_rdata_i    = '0;

        vecs.push_back(mkAlu("ALU5", 5'd5, 1'b1, 32'h0000_1234, 1'b1));
        vecs.push_back(mkAlu("ALUrd0", 5'd0, 1'b1, 32'h0000_DEAD, 1'b0));
        vecs.push_back(mkAlu("ALUnoWe", 5'd7, 1'b0, 32'h0000_0055, 1'b0));
        vecs.push_back(mkMem("LB", 0, 0, 2'd0, 5'd3, 32'h103, 32'h0, 32'h80FF_FFFF, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 1));
        vecs.push_back(mkMem("LBU", 0, 1, 2'd0, 5'd4, 32'h103, 32'h0, 32'h80FF_FFFF, 32'h100, 4'b1000, 32'h0, 32'h0000_0080, 1));
        vecs.push_back(mkMem("SH", 1, 0, 2'd1, 5'd6, 32'h102, 32'h0000_ABCD, 32'h0, 32'h100, 4'b1100, 32'hABCD_ABCD, 32'h0, 0));
        vecs.push_back(mkMem("LH", 0, 0, 2'd1, 5'd7, 32'h102, 32'h0, 32'h8001_1234, 32'h100, 4'b1100, 32'h0, 32'hFFFF_8001, 1));
        vecs.push_back(mkMem("LHU", 0, 1, 2'd1, 5'd8, 32'h100, 32'h0, 32'h1234_F00D, 32'h100, 4'b0011, 32'h0, 32'h0000_F00D, 1));
        vecs.push_back(mkMem("LW", 0, 0, 2'd2, 5'd9, 32'h204, 32'h0, 32'hCAFE_BABE, 32'h204, 4'b1111, 32'h0, 32'hCAFE_BABE, 1));
        vecs.push_back(mkMem("SB", 1, 0, 2'd0, 5'd10, 32'h301, 32'h1234_56A5, 32'h0, 32'h300, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0));
        vecs.push_back(mkMem("SW", 1, 0, 2'd2, 5'd11, 32'h400, 32'h1122_3344, 32'h0, 32'h400, 4'b1111, 32'h1122_3344, 32'h0, 0));
        vecs.push_back(mkMem("LDasW", 0, 0, 2'd3, 5'd12, 32'h208, 32'h0, 32'h8765_4321, 32'h208, 4'b1111, 32'h0, 32'h8765_4321, 1));
        vecs.push_back(mkMem("LBrd0", 0, 0, 2'd0, 5'd0, 32'h500, 32'h0, 32'h0000_007F, 32'h500, 4'b0001, 32'h0, 32'h0000_007F, 0));
`ifndef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mkMem("LWmis", 0, 0, 2'd2, 5'd13, 32'h101, 32'h0, 32'h0102_0304, 32'h100, 4'b1111, 32'h0, 32'h0102_0304, 1));
        vecs.push_back(mkMem("LHmis", 0, 0, 2'd1, 5'd14, 32'h103, 32'h0, 32'hBEEF_0000, 32'h100, 4'b1100, 32'h0, 32'hFFFF_BEEF, 1));
`endif

        // Reset state
        #2;
        checkOutput("rstWbValid", 64'(wb_valid_o), 64'd0);
        checkOutput("rstWbWe", 64'(wb_rd_we_o), 64'd0);
        checkOutput("rstWbData", 64'(wb_rd_data_o), 64'd0);
        checkOutput("rstReq", 64'(dbus_req_o), 64'd0);
        checkOutput("rstBe", 64'(dbus_be_o), 64'd0);
        checkOutput("rstAddr", 64'(dbus_addr_o), 64'd0);
        checkOutput("rstReady", 64'(ex_ready_o), 64'd1);
        stepCycle();
        stepCycle();
        rst_i = 1'b0;
        stepCycle();

        // Table of single operations
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Back-to-back register ops followed by a bubble
        for (int i = 0; i < 3; i++) begin
            v = mkAlu("B2B", 5'(20 + i), 1'b1, 32'hA000_0000 + 32'(i), 1'b1);
            driveEx(v);
            checkOutput("b2bReady", 64'(ex_ready_o), 64'd1);
            pushExp(v.rd, v.expWbData, 1'b1, 1'b1);
            stepCycle();
            checkOutput("b2bWbValid", 64'(wb_valid_o), 64'd1);
        end
        ex_valid_i = 1'b0;
        stepCycle();
        checkOutput("bubbleWbValid", 64'(wb_valid_o), 64'd0);
        checkOutput("bubbleWbWe", 64'(wb_rd_we_o), 64'd0);

        // Bus noise while idle is ignored
        dbus_gnt_i    = 1'b1;
        dbus_rvalid_i = 1'b1;
        stepCycle();
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        checkOutput("idleNoiseReq", 64'(dbus_req_o), 64'd0);
        checkOutput("idleNoiseWb", 64'(wb_valid_o), 64'd0);
        checkOutput("idleNoiseReady", 64'(ex_ready_o), 64'd1);

        // Grant withheld for three cycles, with a stray rvalid while requesting
        v = mkMem("LWstall", 0, 0, 2'd2, 5'd15, 32'h40, 32'h0, 32'h1357_9BDF, 32'h40, 4'b1111, 32'h0, 32'h1357_9BDF, 1);
        driveEx(v);
        stepCycle();
        ex_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stallReq", 64'(dbus_req_o), 64'd1);
            checkOutput("stallAddr", 64'(dbus_addr_o), 64'h40);
            checkOutput("stallBe", 64'(dbus_be_o), 64'hF);
            checkOutput("stallReady", 64'(ex_ready_o), 64'd0);
            checkOutput("stallNoWb", 64'(wb_valid_o), 64'd0);
            dbus_rvalid_i = (i == 0);
            dbus_rdata_i  = 32'hDEAD_BEEF;
            stepCycle();
            dbus_rvalid_i = 1'b0;
        end
        checkOutput("stallReqHeld", 64'(dbus_req_o), 64'd1);
        dbus_gnt_i = 1'b1;
        stepCycle();
        dbus_gnt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("waitNoReq", 64'(dbus_req_o), 64'd0);
            checkOutput("waitReady", 64'(ex_ready_o), 64'd0);
            checkOutput("waitNoWb", 64'(wb_valid_o), 64'd0);
            stepCycle();
        end
        pushExp(v.rd, v.expWbData, 1'b1, 1'b1);
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = v.rdata;
        stepCycle();
        dbus_rvalid_i = 1'b0;
        checkOutput("stallWbValid", 64'(wb_valid_o), 64'd1);

        // Reset in the middle of a transaction, then a late response
        v = mkMem("LWabort", 0, 0, 2'd2, 5'd16, 32'h80, 32'h0, 32'h0, 32'h80, 4'b1111, 32'h0, 32'h0, 1);
        driveEx(v);
        stepCycle();
        ex_valid_i = 1'b0;
        dbus_gnt_i = 1'b1;
        stepCycle();
        dbus_gnt_i = 1'b0;
        checkOutput("abortPreBe", 64'(dbus_be_o), 64'hF);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("abortBe", 64'(dbus_be_o), 64'd0);
        checkOutput("abortAddr", 64'(dbus_addr_o), 64'd0);
        checkOutput("abortReady", 64'(ex_ready_o), 64'd1);
        checkOutput("abortReq", 64'(dbus_req_o), 64'd0);
        stepCycle();
        rst_i         = 1'b0;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'hFFFF_FFFF;
        stepCycle();
        dbus_rvalid_i = 1'b0;
        checkOutput("lateRvalidWb", 64'(wb_valid_o), 64'd0);
        checkOutput("lateRvalidReady", 64'(ex_ready_o), 64'd1);
        applyStimulus(mkAlu("postAbort", 5'd17, 1'b1, 32'h0BAD_CAFE, 1'b1));

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned word load is reported instead of issued
        v = mkMem("LWtrap", 0, 0, 2'd2, 5'd9, 32'h101, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
        driveEx(v);
        pushExp(5'd9, 32'h0, 1'b0, 1'b0);
        stepCycle();
        ex_valid_i = 1'b0;
        checkOutput("trapPulse", 64'(misalign_o), 64'd1);
        checkOutput("trapAddr", 64'(misalign_addr_o), 64'h101);
        checkOutput("trapNoReq", 64'(dbus_req_o), 64'd0);
        checkOutput("trapWbValid", 64'(wb_valid_o), 64'd1);
        checkOutput("trapWbWe", 64'(wb_rd_we_o), 64'd0);
        checkOutput("trapReady", 64'(ex_ready_o), 64'd1);
        stepCycle();
        checkOutput("trapPulseEnd", 64'(misalign_o), 64'd0);
        checkOutput("trapStillNoReq", 64'(dbus_req_o), 64'd0);
`endif

        stepCycle();
        stepCycle();
        checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
